// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache refill/writeback traffic: a word-addressed
// backing store, a latency-delayed read beat stream and request counters.
module cache_mem_responder #(
  parameter int MEM_AW = 12,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [31:0]  rd_cnt,
  output logic [31:0]  wr_cnt
);

  localparam int          DEPTH        = 1 << MEM_AW;
  localparam logic [2:0]  TYPE_LINE    = 3'b100;
  localparam logic [15:0] RD_WAIT_INIT = 16'(RD_LAT - 1);
  localparam logic [15:0] WR_BUSY_INIT = 16'(WR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_BUSY  = 2'd3
  } state_t;

  typedef logic [31:0] mem_t [DEPTH];

  function automatic mem_t mem_pattern();
    mem_t        m;
    logic [15:0] lo;
    for (int i = 0; i < DEPTH; i++) begin
      lo   = 16'(i);
      m[i] = {~lo, lo};
    end
    return m;
  endfunction

  // Power-up contents only; reset never touches the store.
  mem_t mem_r = mem_pattern();

  state_t            state_r;
  logic              rd_rdy_r;
  logic              wr_rdy_r;
  logic              ret_valid_r;
  logic              ret_last_r;
  logic              line_r;
  logic [31:0]       ret_data_r;
  logic [31:0]       rd_cnt_r;
  logic [31:0]       wr_cnt_r;
  logic [15:0]       lat_cnt_r;
  logic [MEM_AW-1:0] rd_idx_r;
  logic [1:0]        beat_r;

  logic              rd_line_s;
  logic              wr_line_s;
  logic              rd_fire_s;
  logic              wr_fire_s;
  logic [MEM_AW-1:0] rd_idx_s;
  logic [MEM_AW-1:0] wr_idx_s;
  logic [MEM_AW-1:0] next_idx_s;
  logic [MEM_AW-3:0] wr_base_s;
  logic              unused_s;

  assign rd_line_s  = (rd_type == TYPE_LINE);
  assign wr_line_s  = (wr_type == TYPE_LINE);
  assign rd_idx_s   = rd_line_s ? {rd_addr[MEM_AW+1:4], 2'b00} : rd_addr[MEM_AW+1:2];
  assign wr_idx_s   = wr_addr[MEM_AW+1:2];
  assign wr_base_s  = wr_addr[MEM_AW+1:4];
  assign next_idx_s = {rd_idx_r[MEM_AW-1:2], beat_r + 2'd1};

  // A write offered in the same idle cycle wins, so a writeback lands before its refill.
  assign rd_rdy    = rd_rdy_r & ~wr_req;
  assign wr_fire_s = wr_req & wr_rdy_r & resetn;
  assign rd_fire_s = rd_req & rd_rdy;

  assign wr_rdy    = wr_rdy_r;
  assign ret_valid = ret_valid_r;
  assign ret_last  = ret_last_r;
  assign ret_data  = ret_data_r;
  assign rd_cnt    = rd_cnt_r;
  assign wr_cnt    = wr_cnt_r;

  assign unused_s = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0], wr_addr[31:MEM_AW+2], wr_addr[1:0]};

  // Request sequencing, latency counting and the registered return beat stream.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      rd_rdy_r    <= 1'b0;
      wr_rdy_r    <= 1'b1;
      ret_valid_r <= 1'b0;
      ret_last_r  <= 1'b0;
      ret_data_r  <= 32'd0;
      rd_cnt_r    <= 32'd0;
      wr_cnt_r    <= 32'd0;
      lat_cnt_r   <= 16'd0;
      rd_idx_r    <= '0;
      beat_r      <= 2'd0;
      line_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rd_rdy_r <= 1'b1;
          wr_rdy_r <= 1'b1;
          if (wr_fire_s) begin
            wr_cnt_r  <= wr_cnt_r + 32'd1;
            rd_rdy_r  <= 1'b0;
            wr_rdy_r  <= 1'b0;
            lat_cnt_r <= WR_BUSY_INIT;
            state_r   <= WR_BUSY;
          end else if (rd_fire_s) begin
            rd_cnt_r <= rd_cnt_r + 32'd1;
            rd_rdy_r <= 1'b0;
            wr_rdy_r <= 1'b0;
            line_r   <= rd_line_s;
            rd_idx_r <= rd_idx_s;
            beat_r   <= 2'd0;
            if (RD_LAT == 1) begin
              ret_valid_r <= 1'b1;
              ret_last_r  <= ~rd_line_s;
              ret_data_r  <= mem_r[rd_idx_s];
              state_r     <= RD_BURST;
            end else begin
              lat_cnt_r <= RD_WAIT_INIT;
              state_r   <= RD_WAIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_r == 16'd1) begin
            ret_valid_r <= 1'b1;
            ret_last_r  <= ~line_r;
            ret_data_r  <= mem_r[rd_idx_r];
            state_r     <= RD_BURST;
          end else begin
            lat_cnt_r <= lat_cnt_r - 16'd1;
          end
        end
        RD_BURST: begin
          if (ret_last_r) begin
            ret_valid_r <= 1'b0;
            ret_last_r  <= 1'b0;
            ret_data_r  <= 32'd0;
            rd_rdy_r    <= 1'b1;
            wr_rdy_r    <= 1'b1;
            state_r     <= IDLE;
          end else begin
            beat_r     <= beat_r + 2'd1;
            ret_data_r <= mem_r[next_idx_s];
            ret_last_r <= (beat_r == 2'd2);
          end
        end
        WR_BUSY: begin
          if (lat_cnt_r == 16'd0) begin
            rd_rdy_r <= 1'b1;
            wr_rdy_r <= 1'b1;
            state_r  <= IDLE;
          end else begin
            lat_cnt_r <= lat_cnt_r - 16'd1;
          end
        end
        default: begin
          state_r     <= IDLE;
          rd_rdy_r    <= 1'b0;
          wr_rdy_r    <= 1'b1;
          ret_valid_r <= 1'b0;
          ret_last_r  <= 1'b0;
          ret_data_r  <= 32'd0;
        end
      endcase
    end
  end

  // Store update on the accepting edge; a line write fills the aligned quad.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      if (wr_line_s) begin
        mem_r[{wr_base_s, 2'd0}] <= wr_data[31:0];
        mem_r[{wr_base_s, 2'd1}] <= wr_data[63:32];
        mem_r[{wr_base_s, 2'd2}] <= wr_data[95:64];
        mem_r[{wr_base_s, 2'd3}] <= wr_data[127:96];
      end else begin
        if (wr_wstrb[0]) mem_r[wr_idx_s][7:0]   <= wr_data[7:0];
        if (wr_wstrb[1]) mem_r[wr_idx_s][15:8]  <= wr_data[15:8];
        if (wr_wstrb[2]) mem_r[wr_idx_s][23:16] <= wr_data[23:16];
        if (wr_wstrb[3]) mem_r[wr_idx_s][31:24] <= wr_data[31:24];
      end
    end
  end

endmodule
